// File: rtl/pc_unit_pkg.sv
// Shared CPU package: next-PC select codes, PC FSM states
// and the default reset vector.
package pc_unit_pkg;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'b00,
    PCS_ALUOUT = 2'b01,
    PCS_JUMP   = 2'b10,
    PCS_HOLD   = 2'b11
  } pcsrc_e;

  typedef enum logic [1:0] {
    ST_RUN    = 2'b00,
    ST_HALTED = 2'b01,
    ST_ERROR  = 2'b10
  } pc_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/pc_next_mux.sv
// Combinational next-PC select: ALU result, registered ALU
// result, pseudo-direct jump target or hold.
module pc_next_mux
  import pc_unit_pkg::*;
(
  input  pcsrc_e      pc_src,
  input  logic [31:0] alu_result,
  input  logic [31:0] alu_out,
  input  logic [31:0] pc,
  input  logic [25:0] jump_field,
  output logic [31:0] next_pc
);

  always_comb begin
    next_pc = pc;
    unique case (pc_src)
      PCS_ALU:    next_pc = alu_result;
      PCS_ALUOUT: next_pc = alu_out;
      PCS_JUMP:   next_pc = {pc[31:28], jump_field, 2'b00};
      PCS_HOLD:   next_pc = pc;
      default:    next_pc = pc;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with load qualification, alignment check,
// halt/error FSM and a saturating accepted-load counter.
module pc_unit
  import pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic [1:0]       PCSource,
  input  logic             halt,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero,
  input  logic [25:0]      jump_field,
  output logic [31:0]      pc,
  output logic [31:0]      alu_out,
  output logic             branch_taken,
  output logic             pc_err,
  output logic             halted,
  output logic [CNT_W-1:0] load_count
);

  pc_state_e        state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      alu_out_q, alu_out_d;
  logic             br_q, br_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] next_pc;
  logic        load_req;
  logic        cond_take;

  pc_next_mux u_mux (
    .pc_src     (pcsrc_e'(PCSource)),
    .alu_result (alu_result),
    .alu_out    (alu_out_q),
    .pc         (pc_q),
    .jump_field (jump_field),
    .next_pc    (next_pc)
  );

  assign cond_take = PCWriteCond & alu_zero;
  assign load_req  = PCWrite | cond_take;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    alu_out_d = alu_result;
    br_d      = 1'b0;
    err_d     = err_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_RUN: begin
        if (halt) begin
          state_d = ST_HALTED;
        end else if (load_req) begin
          if (next_pc[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = ST_ERROR;
          end else begin
            pc_d = next_pc;
            br_d = cond_take & ~PCWrite;
            if (cnt_q != {CNT_W{1'b1}})
              cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      ST_ERROR:  state_d = ST_ERROR;
      default:   state_d = ST_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_PC;
      alu_out_q <= '0;
      br_q      <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      alu_out_q <= alu_out_d;
      br_q      <= br_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign pc           = pc_q;
  assign alu_out      = alu_out_q;
  assign branch_taken = br_q;
  assign pc_err       = err_q;
  assign halted       = (state_q == ST_HALTED);
  assign load_count   = cnt_q;

endmodule
